// File: rtl/psum_acc.sv
// psum_acc: accumulates LANES-wide partial-sum beats over a tile of rounds and queues each
// tile result (optionally ReLU-clamped) in a 2-entry output FIFO.
module psum_acc #(
    parameter int LANES = 36,
    parameter int IN_W  = 24,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             last_round,
    input  logic                   relu_en,
    input  logic                   Psum_valid,
    input  logic [LANES*IN_W-1:0]  Psum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic                   busy,
    output logic [1:0]             err
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t state, state_nx;
    logic [2:0] rnd, last_q, cur_rnd, cur_last;
    logic relu_q, cur_relu, accept, stray, fin, launch;
    logic [ACC_W-1:0] acc [LANES];
    logic [ACC_W-1:0] sum [LANES];
    logic [LANES*ACC_W-1:0] res;
    logic [LANES*ACC_W-1:0] mem [2];
    logic wr_ptr, rd_ptr, pop, full, do_push;
    logic [1:0] cnt;
    // A start in IDLE supplies the config for a beat arriving in the same cycle.
    always_comb begin
        launch   = state == IDLE && start;
        cur_rnd  = state == IDLE ? 3'd0 : rnd;
        cur_last = state == IDLE ? last_round : last_q;
        cur_relu = state == IDLE ? relu_en : relu_q;
        accept   = Psum_valid && (state == ACC || start);
        stray    = Psum_valid && state == IDLE && !start;
        fin      = accept && cur_rnd == cur_last;
        state_nx = (launch && !fin) ? ACC : (state == ACC && fin) ? IDLE : state;
    end
    always_comb begin
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i] = (cur_rnd == 3'd0 ? '0 : acc[i]) + ACC_W'($signed(Psum[IN_W*i +: IN_W]));
            res[ACC_W*i +: ACC_W] = (cur_relu && sum[i][ACC_W-1]) ? '0 : sum[i];
        end
    end
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rd_ptr];
    assign busy      = state == ACC;
    assign pop       = out_valid && out_ready;
    assign full      = cnt == 2'd2;
    assign do_push   = fin && (!full || pop);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd    <= '0;
            last_q <= '0;
            relu_q <= 1'b0;
            err    <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            if (launch) begin
                last_q <= last_round;
                relu_q <= relu_en;
            end
            if (accept) rnd <= fin ? 3'd0 : cur_rnd + 3'd1;
            else if (launch) rnd <= 3'd0;
            if (accept) for (int i = 0; i < LANES; i++) acc[i] <= sum[i];
            err <= err | {fin && full && !pop, stray};
        end
    end
    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= res;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(do_push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: randomized and directed checks of psum_acc against a lane-sum reference model.
module tb_psum_acc;
    localparam int LANES = 36, IN_W = 24, ACC_W = 32, OW = LANES*ACC_W;
    localparam int WL = 4, WW = WL*24;
    logic clk = 0, rst = 1, start = 0, relu_en = 0, Psum_valid = 0, out_ready = 0;
    logic [2:0] last_round = 0;
    logic [LANES*IN_W-1:0] Psum = '0;
    logic out_valid, busy, w_valid, w_busy;
    logic [OW-1:0] out_data;
    logic [WW-1:0] w_data;
    logic [1:0] err, w_err;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    psum_acc dut (.clk(clk), .rst(rst), .start(start), .last_round(last_round), .relu_en(relu_en),
        .Psum_valid(Psum_valid), .Psum(Psum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .err(err));

    // Narrow instance whose accumulator is only as wide as the input lanes, to observe wrap.
    psum_acc #(.LANES(WL), .IN_W(24), .ACC_W(24)) dut_w (.clk(clk), .rst(rst), .start(start),
        .last_round(last_round), .relu_en(relu_en), .Psum_valid(Psum_valid), .Psum(Psum[WW-1:0]),
        .out_valid(w_valid), .out_ready(out_ready), .out_data(w_data), .busy(w_busy), .err(w_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; Psum_valid = 0;
        tick(); tick();
        rst = 0;
    endtask

    // Drives one full tile and returns the expected result computed from the lane sums.
    task automatic run_tile(input logic [2:0] lr, input logic rl, input bit merge, input bit gaps,
                            input bit use_fill, input logic [IN_W-1:0] fill,
                            output logic [OW-1:0] e, output logic [WW-1:0] ew);
        longint s [LANES];
        logic signed [IN_W-1:0] v;
        logic [ACC_W-1:0] t32;
        logic [23:0] t24;
        for (int i = 0; i < LANES; i++) s[i] = 0;
        start = 1; last_round = lr; relu_en = rl;
        if (!merge) begin
            Psum_valid = 0;
            tick();
            start = 0;
        end
        for (int r = 0; r <= int'(lr); r++) begin
            while (gaps && r > 0 && $urandom_range(0, 2) == 0) begin
                start = 1'($urandom_range(0, 1)); last_round = 3'($urandom); relu_en = 1'($urandom);
                Psum_valid = 0;
                tick();
                start = 0;
            end
            for (int i = 0; i < LANES; i++) begin
                v = use_fill ? fill : IN_W'($urandom);
                Psum[IN_W*i +: IN_W] = v;
                s[i] = s[i] + v;
            end
            Psum_valid = 1;
            tick();
            Psum_valid = 0; start = 0;
        end
        for (int i = 0; i < LANES; i++) begin
            t32 = s[i][ACC_W-1:0];
            e[ACC_W*i +: ACC_W] = (rl && t32[ACC_W-1]) ? '0 : t32;
        end
        for (int i = 0; i < WL; i++) begin
            t24 = s[i][23:0];
            ew[24*i +: 24] = (rl && t24[23]) ? '0 : t24;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    endtask

    task automatic test_basic();
        logic [OW-1:0] e, x;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 1;
        start = 1; last_round = 2; relu_en = 0;
        tick();
        start = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < LANES; i++) Psum[IN_W*i +: IN_W] = 24'd5;
            Psum_valid = 1;
            tick();
            Psum_valid = 0;
            if (r < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early got=%b exp=0", out_valid); end
            end
        end
        for (int i = 0; i < LANES; i++) x[ACC_W*i +: ACC_W] = 32'd15;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== x) begin failures++; $display("FAIL basic_data got=%h exp=%h", out_data, x); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_single got=%b exp=0", out_valid); end
        e = '0; ew = '0;
    endtask

    task automatic test_relu();
        logic [OW-1:0] e;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 0;
        run_tile(0, 0, 1, 0, 1, 24'hFFFFFD, e, ew);
        checks++; if (out_data[31:0] !== 32'hFFFFFFFD) begin failures++; $display("FAIL relu_off got=%h exp=fffffffd", out_data[31:0]); end
        out_ready = 1; tick(); out_ready = 0;
        run_tile(0, 1, 1, 0, 1, 24'hFFFFFD, e, ew);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL relu_valid got=%b exp=1", out_valid); end
        checks++; if (out_data[31:0] !== 32'h0) begin failures++; $display("FAIL relu_on got=%h exp=0", out_data[31:0]); end
        checks++; if (out_data !== e) begin failures++; $display("FAIL relu_all got=%h exp=%h", out_data, e); end
        out_ready = 1; tick();
    endtask

    task automatic test_max();
        logic [OW-1:0] e;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 1;
        run_tile(7, 0, 0, 1, 1, 24'h7FFFFF, e, ew);
        checks++; if (out_data[31:0] !== 32'h03FFFFF8) begin failures++; $display("FAIL max_lane got=%h exp=03fffff8", out_data[31:0]); end
        checks++; if (out_data !== e) begin failures++; $display("FAIL max_all got=%h exp=%h", out_data, e); end
        checks++; if (w_data[23:0] !== 24'hFFFFF8) begin failures++; $display("FAIL wrap_lane got=%h exp=fffff8", w_data[23:0]); end
        checks++; if (w_valid !== 1'b1 || w_data !== ew) begin failures++; $display("FAIL wrap_all got=%h exp=%h", w_data, ew); end
        tick();
    endtask

    task automatic test_random();
        logic [OW-1:0] e;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 1;
        for (int n = 0; n < 16; n++) begin
            run_tile(3'($urandom), 1'($urandom), 1'($urandom), 1, 0, '0, e, ew);
            checks++; if (out_valid !== 1'b1 || out_data !== e) begin failures++; $display("FAIL rand_tile%0d got=%h exp=%h", n, out_data, e); end
            checks++; if (w_data !== ew) begin failures++; $display("FAIL rand_wrap%0d got=%h exp=%h", n, w_data, ew); end
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL rand_err got=%b exp=00", err); end
    endtask

    task automatic test_fifo();
        logic [OW-1:0] e1, e2, e3;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 0;
        run_tile(0, 0, 1, 0, 0, '0, e1, ew);
        run_tile(0, 0, 1, 0, 0, '0, e2, ew);
        checks++; if (out_data !== e1) begin failures++; $display("FAIL fifo_hold got=%h exp=%h", out_data, e1); end
        run_tile(0, 0, 1, 0, 0, '0, e3, ew);
        tick();
        checks++; if (err !== 2'b10) begin failures++; $display("FAIL fifo_err got=%b exp=10", err); end
        checks++; if (out_valid !== 1'b1 || out_data !== e1) begin failures++; $display("FAIL fifo_head got=%h exp=%h", out_data, e1); end
        out_ready = 1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== e2) begin failures++; $display("FAIL fifo_second got=%h exp=%h", out_data, e2); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fifo_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] e1, e2, e3;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 0;
        run_tile(0, 0, 1, 0, 0, '0, e1, ew);
        run_tile(1, 1, 1, 0, 0, '0, e2, ew);
        out_ready = 1;
        run_tile(0, 0, 1, 0, 0, '0, e3, ew);
        checks++; if (out_valid !== 1'b1 || out_data !== e2) begin failures++; $display("FAIL b2b_second got=%h exp=%h", out_data, e2); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL b2b_err got=%b exp=00", err); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== e3) begin failures++; $display("FAIL b2b_third got=%h exp=%h", out_data, e3); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_stray_abort();
        logic [OW-1:0] e;
        logic [WW-1:0] ew;
        do_reset();
        out_ready = 1;
        Psum = {LANES{24'h000011}}; Psum_valid = 1;
        tick();
        Psum_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stray_valid got=%b exp=0", out_valid); end
        checks++; if (err !== 2'b01) begin failures++; $display("FAIL stray_err got=%b exp=01", err); end
        do_reset();
        start = 1; last_round = 3; Psum_valid = 1;
        tick();
        start = 0; rst = 1;
        tick();
        rst = 0; Psum_valid = 0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 2'b00) begin
                failures++; $display("FAIL abort_idle%0d got=%b%b%b exp=0000", k, out_valid, busy, err);
            end
            tick();
        end
        run_tile(3, 0, 0, 1, 0, '0, e, ew);
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin failures++; $display("FAIL abort_next got=%h exp=%h", out_data, e); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_max();
        test_random();
        test_fifo();
        test_back_to_back();
        test_stray_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 Parameter LANES, default 36, number of partial-sum lanes in one Psum beat.
REQ-002 Parameter IN_W, default 24, signed width of one input lane (LANES*IN_W = 864).
REQ-003 Parameter ACC_W, default 32, signed width of one accumulator/output lane.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle pulse, begins a tile; samples last_round and relu_en.
REQ-007 last_round  input  3  index of the final round of the tile (tile = last_round+1 beats, 1..8).
REQ-008 relu_en  input  1  clamp negative lanes to 0 on output.
REQ-009 Psum_valid  input  1  Psum beat present this cycle (from ADDER, no backpressure).
REQ-010 Psum  input  LANES*IN_W  lane i = Psum[IN_W*i+IN_W-1 : IN_W*i], two's complement.
REQ-011 out_valid  output  1  out_data holds an unread tile result.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-013 out_data  output  LANES*ACC_W  tile result, lane i at [ACC_W*i+ACC_W-1 : ACC_W*i].
REQ-014 busy  output  1  high in state ACC.
REQ-015 err  output  2  sticky: bit0 = stray beat, bit1 = result dropped (FIFO full).

Function
REQ-016 FSM states IDLE and ACC; reset state IDLE.
REQ-017 IDLE->ACC on start; round counter <= 0; last_round/relu_en latched.
REQ-018 A Psum_valid in the same cycle as start is accepted as round 0.
REQ-019 start while in ACC is ignored; latched config is unchanged.
REQ-020 In ACC each Psum_valid beat is accepted; round 0 loads acc[i] = sext(lane i); later rounds acc[i] = acc[i] + sext(lane i).
REQ-021 Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
REQ-022 Beat whose round index equals latched last_round is the final beat: final value (after optional ReLU, negative -> 0) is pushed into the output FIFO and FSM returns to IDLE.
REQ-023 Non-final beat increments round counter; FSM stays in ACC.
REQ-024 Psum_valid in IDLE without start is discarded and sets err[0].
REQ-025 Output FIFO depth 2, first-in first-out; out_valid = FIFO not empty; out_data = head entry.
REQ-026 Latency: final beat at rising edge t -> out_valid=1 with that result after edge t (visible cycle t+1) when FIFO was empty.
REQ-027 Push when FIFO full and no pop in same cycle: result dropped, err[1] set, FSM still returns to IDLE.
REQ-028 Push and pop in same cycle with FIFO full: both succeed, count stays 2, order preserved.
REQ-029 out_data stable while out_valid=1 and out_ready=0.
REQ-030 err bits clear only on rst.

Reset
REQ-031 rst=1 at a rising edge: state IDLE, round counter 0, accumulators 0, FIFO empty, out_valid=0, busy=0, err=0, out_data=0.
REQ-032 rst mid-tile aborts the tile; no partial result is ever emitted; beats in the rst cycle are ignored.

Verification
REQ-033 start, last_round=2, three beats all lanes +5 -> single out_valid cycle t+1 after third beat, every lane 15.
REQ-034 start+Psum_valid same cycle, last_round=0, lane0=-3 (0xFFFFFD), relu_en=0 -> lane0 out 0xFFFFFFFD; repeat with relu_en=1 -> lane0 out 0.
REQ-035 Eight beats of lane value 0x7FFFFF, last_round=7 -> lane out 0x03FFFFF8; ACC_W wrap check with forced ACC_W=24 -> wraps modulo 2^24.
REQ-036 out_ready=0, three single-beat tiles -> first two held in order, third dropped, err=2'b10; then out_ready=1 -> two results drain in order.
REQ-037 Psum_valid in IDLE without start -> no output, err[0]=1; rst mid-tile after 1 of 4 beats -> out_valid stays 0, err=0, next tile correct.
